// File: rtl/ahbl_master.sv
// AHB-Lite single-transfer master: turns a req/gnt/rvalid request port into
// pipelined NONSEQ SINGLE transfers, with the two-cycle ERROR response handled.
module ahbl_master #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst,
  // request port
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  // AHB-Lite master side
  output logic [ADDR_WIDTH-1:0] ahbl_haddr,
  output logic [2:0]            ahbl_hburst,
  output logic                  ahbl_hmastlock,
  output logic [3:0]            ahbl_hprot,
  output logic [2:0]            ahbl_hsize,
  output logic [1:0]            ahbl_htrans,
  output logic [DATA_WIDTH-1:0] ahbl_hwdata,
  output logic                  ahbl_hwrite,
  input  logic [DATA_WIDTH-1:0] ahbl_hrdata,
  input  logic                  ahbl_hready,
  input  logic                  ahbl_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic                  dphase_valid;
  logic                  dphase_we;
  logic [DATA_WIDTH-1:0] dphase_wdata;
  logic                  err_first_q;
  logic                  err_cycle;
  logic                  err_first;
  logic                  addr_ok;
  logic [1:0]            addr_lsb;

  // First ERROR cycle is seen combinationally and remembered for the second,
  // so no new address phase is issued across either cycle of the response.
  assign err_cycle = dphase_valid & ahbl_hresp & ~ahbl_hready;
  assign err_first = err_cycle | err_first_q;
  assign addr_ok   = req_i & ~err_first & ~rst;

  assign ahbl_hburst    = 3'b000;
  assign ahbl_hmastlock = 1'b0;
  assign ahbl_hprot     = HPROT_VAL;
  assign ahbl_htrans    = addr_ok ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahbl_hwrite    = we_i;
  assign ahbl_haddr     = {addr_i[ADDR_WIDTH-1:2], addr_lsb};
  assign ahbl_hwdata    = dphase_wdata;

  assign gnt_o    = addr_ok & ahbl_hready;
  assign rvalid_o = dphase_valid & ahbl_hready;
  assign err_o    = rvalid_o & ahbl_hresp;
  assign rdata_o  = (dphase_valid & ~dphase_we) ? ahbl_hrdata : '0;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ahbl_hsize = 3'b010;
    addr_lsb   = 2'b00;
    case (be_i)
      4'b1111: ahbl_hsize = 3'b010;
      4'b0011: ahbl_hsize = 3'b001;
      4'b1100: begin ahbl_hsize = 3'b001; addr_lsb = 2'b10; end
      4'b0001: ahbl_hsize = 3'b000;
      4'b0010: begin ahbl_hsize = 3'b000; addr_lsb = 2'b01; end
      4'b0100: begin ahbl_hsize = 3'b000; addr_lsb = 2'b10; end
      4'b1000: begin ahbl_hsize = 3'b000; addr_lsb = 2'b11; end
      default: begin ahbl_hsize = 3'b010; addr_lsb = 2'b00; end
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dphase_valid <= 1'b0;
      dphase_we    <= 1'b0;
      dphase_wdata <= '0;
      err_first_q  <= 1'b0;
    end else begin
      err_first_q <= err_cycle;
      if (gnt_o) begin
        dphase_valid <= 1'b1;
        dphase_we    <= we_i;
        dphase_wdata <= wdata_i;
      end else if (ahbl_hready) begin
        dphase_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_master.sv
// Directed bench for ahbl_master: the bench drives the slave response itself
// and checks every cycle against hand-computed values.
module tb_ahbl_master;

  logic        clk;
  logic        rst;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [31:0] ahbl_haddr, ahbl_hwdata, ahbl_hrdata;
  logic [2:0]  ahbl_hburst, ahbl_hsize;
  logic        ahbl_hmastlock, ahbl_hwrite, ahbl_hready, ahbl_hresp;
  logic [3:0]  ahbl_hprot;
  logic [1:0]  ahbl_htrans;

  int n_checks = 0;
  int n_fail   = 0;

  ahbl_master dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .ahbl_haddr(ahbl_haddr), .ahbl_hburst(ahbl_hburst), .ahbl_hmastlock(ahbl_hmastlock),
    .ahbl_hprot(ahbl_hprot), .ahbl_hsize(ahbl_hsize), .ahbl_htrans(ahbl_htrans),
    .ahbl_hwdata(ahbl_hwdata), .ahbl_hwrite(ahbl_hwrite), .ahbl_hrdata(ahbl_hrdata),
    .ahbl_hready(ahbl_hready), .ahbl_hresp(ahbl_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance past the next rising edge; inputs are changed right after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
  endtask

  task automatic slave(input logic ready, input logic resp, input logic [31:0] rdata);
    ahbl_hready = ready; ahbl_hresp = resp; ahbl_hrdata = rdata;
  endtask

  logic [3:0]  be_tab    [6] = '{4'b0010, 4'b1000, 4'b1100, 4'b0011, 4'b0001, 4'b0101};
  logic [2:0]  size_tab  [6] = '{3'b000,  3'b000,  3'b001,  3'b001,  3'b000,  3'b010};
  logic [31:0] haddr_tab [6] = '{32'h611, 32'h613, 32'h612, 32'h610, 32'h610, 32'h610};

  initial begin
    // reset: request already asserted, must not be granted
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    #2;
    check("rst_gnt",    gnt_o, 0);
    check("rst_htrans", ahbl_htrans, 2'b00);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_err",    err_o, 0);
    check("rst_hwdata", ahbl_hwdata, 0);
    check("hburst",     ahbl_hburst, 3'b000);
    check("hmastlock",  ahbl_hmastlock, 0);
    check("hprot",      ahbl_hprot, 4'b0011);
    tick();

    // read word, granted in the first cycle out of reset
    rst = 1'b0;
    #2;
    check("rd_gnt",    gnt_o, 1);
    check("rd_htrans", ahbl_htrans, 2'b10);
    check("rd_haddr",  ahbl_haddr, 32'h100);
    check("rd_hsize",  ahbl_hsize, 3'b010);
    check("rd_hwrite", ahbl_hwrite, 0);
    tick();
    drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    slave(1'b1, 1'b0, 32'hDEADBEEF);
    #2;
    check("rd_rvalid", rvalid_o, 1);
    check("rd_rdata",  rdata_o, 32'hDEADBEEF);
    check("rd_err",    err_o, 0);
    check("rd_idle",   ahbl_htrans, 2'b00);
    tick();
    #2;
    check("rd_rvalid_once", rvalid_o, 0);

    // write byte lane 2
    drive(1'b1, 1'b1, 4'b0100, 32'h200, 32'h00AB0000);
    #2;
    check("wb_gnt",    gnt_o, 1);
    check("wb_haddr",  ahbl_haddr, 32'h202);
    check("wb_hsize",  ahbl_hsize, 3'b000);
    check("wb_hwrite", ahbl_hwrite, 1);
    tick();
    drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    #2;
    check("wb_hwdata", ahbl_hwdata, 32'h00AB0000);
    check("wb_rvalid", rvalid_o, 1);
    check("wb_err",    err_o, 0);
    tick();

    // byte-enable decoding table, address low bits forced from be_i
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, be_tab[i], 32'h610, 32'h0);
      #1;
      check($sformatf("be_size%0d", i),  ahbl_hsize, size_tab[i]);
      check($sformatf("be_haddr%0d", i), ahbl_haddr, haddr_tab[i]);
    end
    tick();

    // write with three wait states; next request waits, then pipelines in
    drive(1'b1, 1'b1, 4'hF, 32'h300, 32'h12345678);
    #2;
    check("ws_gnt0", gnt_o, 1);
    tick();
    drive(1'b1, 1'b1, 4'hF, 32'h304, 32'h9ABCDEF0);
    slave(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("ws_nognt%0d", i),  gnt_o, 0);
      check($sformatf("ws_norv%0d", i),   rvalid_o, 0);
      check($sformatf("ws_hwdata%0d", i), ahbl_hwdata, 32'h12345678);
      tick();
    end
    slave(1'b1, 1'b0, 32'h0);
    #2;
    check("ws_rvalid", rvalid_o, 1);
    check("ws_hwdata", ahbl_hwdata, 32'h12345678);
    check("ws_gnt1",   gnt_o, 1);
    tick();
    drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    #2;
    check("ws_rvalid2", rvalid_o, 1);
    check("ws_hwdata2", ahbl_hwdata, 32'h9ABCDEF0);
    tick();
    #2;
    check("ws_quiet", rvalid_o, 0);

    // four back-to-back reads at zero wait states
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 1'b0, 4'hF, 32'(4 * i), 32'h0);
      else       drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
      slave(1'b1, 1'b0, 32'hC0DE0000 + 32'(i));
      #2;
      check($sformatf("b2b_gnt%0d", i), gnt_o, (i < 4) ? 1'b1 : 1'b0);
      if (i < 4) check($sformatf("b2b_haddr%0d", i), ahbl_haddr, 32'(4 * i));
      check($sformatf("b2b_rv%0d", i), rvalid_o, (i > 0) ? 1'b1 : 1'b0);
      if (i > 0) check($sformatf("b2b_rdata%0d", i), rdata_o, 32'hC0DE0000 + 32'(i));
      tick();
    end
    #2;
    check("b2b_end", rvalid_o, 0);

    // hresp with no data phase outstanding is ignored
    drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    slave(1'b1, 1'b1, 32'h0);
    #1;
    check("stray_rv",  rvalid_o, 0);
    check("stray_err", err_o, 0);
    drive(1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
    slave(1'b0, 1'b1, 32'h0);
    #1;
    check("stray_htrans", ahbl_htrans, 2'b10);
    tick();

    // two-cycle ERROR response
    slave(1'b1, 1'b0, 32'h0);
    #2;
    check("er_gnt0", gnt_o, 1);
    tick();
    drive(1'b1, 1'b0, 4'hF, 32'h404, 32'h0);
    slave(1'b0, 1'b1, 32'h0);
    #2;
    check("er1_htrans", ahbl_htrans, 2'b00);
    check("er1_gnt",    gnt_o, 0);
    check("er1_rv",     rvalid_o, 0);
    check("er1_err",    err_o, 0);
    tick();
    slave(1'b1, 1'b1, 32'h0);
    #2;
    check("er2_rv",     rvalid_o, 1);
    check("er2_err",    err_o, 1);
    check("er2_gnt",    gnt_o, 0);
    check("er2_htrans", ahbl_htrans, 2'b00);
    tick();
    slave(1'b1, 1'b0, 32'h55);
    #2;
    check("er3_gnt", gnt_o, 1);
    check("er3_rv",  rvalid_o, 0);
    tick();
    drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    #2;
    check("er4_rv",  rvalid_o, 1);
    check("er4_err", err_o, 0);
    tick();

    // reset pulse in the middle of a wait state
    drive(1'b1, 1'b1, 4'hF, 32'h500, 32'h55AA55AA);
    #2;
    check("rw_gnt", gnt_o, 1);
    tick();
    drive(1'b1, 1'b1, 4'hF, 32'h504, 32'h11111111);
    slave(1'b0, 1'b0, 32'h0);
    #2;
    check("rw_hwdata", ahbl_hwdata, 32'h55AA55AA);
    rst = 1'b1;
    #1;
    check("rw_htrans", ahbl_htrans, 2'b00);
    check("rw_hwdata0", ahbl_hwdata, 0);
    check("rw_gnt0",   gnt_o, 0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    #2;
    check("rw_norv0", rvalid_o, 0);
    tick();
    #2;
    check("rw_norv1", rvalid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
